// File: rtl/cla_mw_pkg.sv
// Shared types and width helpers for the multi-word add sequencer.
package cla_mw_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wait counter must reach ADD_LAT.
  function automatic int unsigned cnt_width(input int unsigned add_lat);
    return $clog2(add_lat + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/cla_32_mw_seq.sv
// Multi-word add sequencer: feeds a pipelined 32-bit adder one word at a time,
// LSW first, chaining carries, and returns the wide sum via valid/ready.
module cla_32_mw_seq
  import cla_mw_pkg::*;
#(
  parameter int unsigned WORDS   = 4,
  parameter int unsigned ADD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W*WORDS-1:0]   in_a,
  input  logic [WORD_W*WORDS-1:0]   in_b,
  input  logic                      in_cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      out_ovf,
  output logic [WORD_W-1:0]         add_a,
  output logic [WORD_W-1:0]         add_b,
  output logic                      add_cin,
  input  logic [WORD_W-1:0]         add_sum,
  input  logic                      add_cout,
  output logic                      busy
);

  localparam int unsigned CNT_W = cnt_width(ADD_LAT);
  localparam int unsigned IDX_W = idx_width(WORDS);

  typedef logic [WORDS-1:0][WORD_W-1:0] wide_t;

  state_e             state_q, state_d;
  wide_t              a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  add_a_d, add_b_d;
  logic               add_cin_d;
  logic               out_valid_d, out_cout_d, out_ovf_d;
  logic               in_ready_d, busy_d;

  assign out_sum = sum_q;
  assign idx_nx  = idx_q + 1'b1;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      out_valid <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      add_a     <= add_a_d;
      add_b     <= add_b_d;
      add_cin   <= add_cin_d;
      out_valid <= out_valid_d;
      out_cout  <= out_cout_d;
      out_ovf   <= out_ovf_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

  // Next-state, word-select mux and capture demux.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a;
    add_b_d     = add_b;
    add_cin_d   = add_cin;
    out_valid_d = out_valid;
    out_cout_d  = out_cout;
    out_ovf_d   = out_ovf;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d       = in_a;
          b_d       = in_b;
          add_a_d   = in_a[WORD_W-1:0];
          add_b_d   = in_b[WORD_W-1:0];
          add_cin_d = in_cin;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Sample only once the word loaded ADD_LAT+1 edges ago has drained out.
        if (cnt_q == CNT_W'(ADD_LAT)) begin
          sum_d[idx_q] = add_sum;
          if (idx_q != IDX_W'(WORDS - 1)) begin
            idx_d     = idx_nx;
            add_a_d   = a_q[idx_nx];
            add_b_d   = b_q[idx_nx];
            add_cin_d = add_cout;
            cnt_d     = '0;
          end else begin
            out_cout_d  = add_cout;
            out_ovf_d   = (a_q[WORDS-1][WORD_W-1] == b_q[WORDS-1][WORD_W-1]) &&
                          (add_sum[WORD_W-1] != a_q[WORDS-1][WORD_W-1]);
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

endmodule

// File: tb/tb_cla_32_mw_seq.sv
// Randomized bench for cla_32_mw_seq paired with a 2-stage 32-bit adder model.
module tb_cla_32_mw_seq;

  localparam int unsigned W = 128;

  logic          clk, reset;
  logic          in_valid, in_ready, in_cin;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic          out_valid, out_ready, out_cout, out_ovf, busy;
  logic [31:0]   add_a, add_b, add_sum;
  logic          add_cin, add_cout;

  int n_vec = 0;
  int n_err = 0;

  logic         pend;
  logic [W-1:0] pend_a, pend_b;

  cla_32_mw_seq #(.WORDS(4), .ADD_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy)
  );

  // Adder stand-in: inputs sampled at one edge, result out after the next.
  logic [32:0] stg1, stg2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg1 <= '0;
      stg2 <= '0;
    end else begin
      stg1 <= 33'(add_a) + 33'(add_b) + 33'(add_cin);
      stg2 <= stg1;
    end
  end
  assign add_sum  = stg2[31:0];
  assign add_cout = stg2[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum} from plain unsigned and signed wide arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    logic [W:0]          u;
    logic signed [W+1:0] s;
    logic                ovf;
    u   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    s   = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed((W+2)'(cin));
    ovf = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
    return {ovf, u};
  endfunction

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int hold, input bit chk_cin);
    int           waited;
    int           lat;
    logic [W+1:0] exp;
    logic [W-1:0] held;
    waited = 0;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp = ref_add(a, b, cin);
    check("busy_after_accept", busy, 1);
    check("in_ready_after_accept", in_ready, 0);
    check("add_a_w0", add_a, a[31:0]);
    check("add_cin_w0", add_cin, cin);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
      if (lat % 3 == 0 && lat < 12) begin
        check("add_a_word", add_a, a[32*(lat/3) +: 32]);
        check("add_b_word", add_b, b[32*(lat/3) +: 32]);
        if (chk_cin) check("add_cin_chain", add_cin, 1);
      end
    end
    check("latency", lat, 12);
    check("out_sum", out_sum, exp[W-1:0]);
    check("out_cout", out_cout, exp[W]);
    check("out_ovf", out_ovf, exp[W+1]);
    held = out_sum;
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (pend) begin
        in_valid = 1'b1; in_a = pend_a; in_b = pend_b; in_cin = 1'b0;
      end
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_sum_stable", out_sum, held);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W+1:0] e5;
    bit           saw;
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b0; pend = 1'b0; pend_a = '0; pend_b = '0;

    // Reset held for three edges.
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();
    check("in_ready_after_reset", in_ready, 1);

    run_add(128'd1, 128'd1, 1'b0, 0, 1'b0);
    run_add({W{1'b1}}, 128'd1, 1'b0, 0, 1'b1);
    run_add({1'b0, {(W-1){1'b1}}}, 128'd0, 1'b1, 0, 1'b0);

    // Backpressure with a new pair already offered.
    pend = 1'b1; pend_a = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321; pend_b = 128'd99;
    run_add(128'd10, 128'd20, 1'b0, 5, 1'b0);
    pend = 1'b0;
    check("pend_ready_next", in_ready, 1);
    run_add(pend_a, pend_b, 1'b0, 0, 1'b0);

    // Reset while the third word is in flight.
    ra = 128'hdead_beef_0000_0001_ffff_ffff_0000_0002;
    rb = 128'h0000_0001_ffff_ffff_0000_0003_0000_0004;
    in_a = ra; in_b = rb; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("mid_run_word2", add_a, ra[95:64]);
    reset = 1'b0;
    tick();
    check("abort_out_valid", out_valid, 0);
    check("abort_out_sum", out_sum, 0);
    check("abort_out_cout", out_cout, 0);
    check("abort_add_a", add_a, 0);
    check("abort_add_b", add_b, 0);
    check("abort_add_cin", add_cin, 0);
    check("abort_busy", busy, 0);
    reset = 1'b1;
    tick();
    check("abort_in_ready", in_ready, 1);
    saw = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    check("abort_no_valid", saw, 0);
    run_add(128'd5, 128'd7, 1'b0, 0, 1'b0);
    e5 = ref_add(128'd5, 128'd7, 1'b0);
    check("post_abort_sum", out_sum, e5[W-1:0]);

    // Random operands with frequent all-ones/all-zero words for long carry chains.
    for (int t = 0; t < 40; t++) begin
      for (int w = 0; w < 4; w++) begin
        case ($urandom_range(0, 3))
          0:       ra[32*w +: 32] = 32'hffff_ffff;
          1:       ra[32*w +: 32] = 32'h0;
          default: ra[32*w +: 32] = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0:       rb[32*w +: 32] = 32'hffff_ffff;
          1:       rb[32*w +: 32] = 32'h0;
          default: rb[32*w +: 32] = $urandom;
        endcase
      end
      run_add(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
